mc_memory: RTL and testbench

- Unified instruction/data memory that answers the multicycle MIPS core's memory port. The core drives Adr, memoryWD and MemWrite; this block returns memoryRD.
- Includes a boot loader FSM that receives a big-endian byte stream over a valid/ready port and packs it into words from word 0 upward. The core is held off, via cpu_run, until the load completes.
- Sits beside the core at top level; the only other external interface is the loader stream.

---
 rtl/mc_mem_pkg.sv | 19 +
 rtl/mc_word_assembler.sv | 63 ++++++
 rtl/mc_memory.sv | 148 ++++++++++++++
 tb/tb_mc_memory.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_mem_pkg.sv
// Shared definitions for the mc_memory block: loader/run state encoding,
// word and byte geometry, and the big-endian byte-lane helper.
package mc_mem_pkg;

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  // Shift amount that places byte k of a word, big-endian (k = 0 is the MSB).
  function automatic logic [4:0] byte_lane(input logic [1:0] k);
    return 5'd24 - {k, 3'b000};
  endfunction

endpackage

// File: rtl/mc_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset; discards any partial word
//   byte_i       incoming byte
//   accept_i     byte_i is taken on this edge
//   last_i       accepted byte is the final one of the image
//   word_o       assembled word including the byte being accepted now
//                (missing low bytes read as zero); valid when word_done_o
//   word_done_o  word_o commits on this edge (fourth byte or last byte)
//   byte_cnt_o   index of the next byte within the current word
module mc_word_assembler
  import mc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              accept_i,
  input  logic              last_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o,
  output logic [1:0]        byte_cnt_o
);

  logic [WORD_W-1:0] asm_q, asm_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] merged;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    merged      = asm_q | (WORD_W'(byte_i) << byte_lane(cnt_q));
    word_done_o = accept_i && ((cnt_q == 2'(BYTES_PER_WORD - 1)) || last_i);
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    if (accept_i) begin
      if (word_done_o) begin
        asm_d = '0;
        cnt_d = '0;
      end else begin
        asm_d = merged;
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o     = merged;
  assign byte_cnt_o = cnt_q;

endmodule

// File: rtl/mc_memory.sv
// Unified instruction/data memory for the multicycle MIPS core, with a boot
// loader that fills the array from a byte stream before releasing the core.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   Adr         byte address from the core; [ADDR_BITS+1:2] selects the word
//   memoryWD    core write data
//   MemWrite    core write strobe
//   memoryRD    combinational read data to the core (0 while loading)
//   ld_valid    loader byte valid
//   ld_byte     loader byte (big-endian within a word)
//   ld_last     final byte of the image
//   ld_ready    loader byte accepted this cycle (high only while loading)
//   cpu_run     core may run; drives the core's reset
//   load_words  words written by the loader (saturates at 2**ADDR_BITS)
//   err         sticky: loader overflow, out-of-range or misaligned write
module mc_memory
  import mc_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    Adr,
  input  logic [WORD_W-1:0]    memoryWD,
  input  logic                 MemWrite,
  output logic [WORD_W-1:0]    memoryRD,
  input  logic                 ld_valid,
  input  logic [BYTE_W-1:0]    ld_byte,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 cpu_run,
  output logic [ADDR_BITS:0]   load_words,
  output logic                 err
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam state_e RESET_STATE = BOOT_LOAD ? S_LOAD : S_RUN;

  state_e               state_q, state_d;
  logic [ADDR_BITS:0]   load_words_q, load_words_d;
  logic                 err_q, err_d;
  logic [WORD_W-1:0]    mem [DEPTH];

  logic                 run;
  logic                 accept;
  logic [WORD_W-1:0]    asm_word;
  logic                 word_done;
  logic [1:0]           byte_cnt;

  logic [ADDR_BITS-1:0] core_idx;
  logic                 out_of_range;
  logic                 misaligned;

  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  logic [WORD_W-1:0]    wdata;

  assign run      = (state_q == S_RUN);
  assign ld_ready = !run;
  assign cpu_run  = run;
  assign accept   = ld_valid && ld_ready;

  mc_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (reset),
    .byte_i      (ld_byte),
    .accept_i    (accept),
    .last_i      (ld_last),
    .word_o      (asm_word),
    .word_done_o (word_done),
    .byte_cnt_o  (byte_cnt)
  );

  assign core_idx     = Adr[ADDR_BITS+1:2];
  assign out_of_range = (Adr >> (ADDR_BITS + 2)) != '0;
  assign misaligned   = Adr[1:0] != 2'b00;

  // Read port is asynchronous so the core's fetch/memory-read states see data
  // in the same cycle; a write on this edge is visible only afterwards.
  assign memoryRD = (run && !out_of_range) ? mem[core_idx] : '0;

  // Single write port: the loader owns it in S_LOAD, the core in S_RUN.
  always_comb begin
    state_d      = state_q;
    load_words_d = load_words_q;
    err_d        = err_q;
    we           = 1'b0;
    waddr        = core_idx;
    wdata        = memoryWD;
    case (state_q)
      S_LOAD: begin
        if (word_done) begin
          // load_words never exceeds DEPTH, so its MSB alone flags "full".
          if (load_words_q[ADDR_BITS]) begin
            err_d = 1'b1;
          end else begin
            we           = 1'b1;
            waddr        = load_words_q[ADDR_BITS-1:0];
            wdata        = asm_word;
            load_words_d = load_words_q + 1'b1;
          end
        end
        if (accept && ld_last) state_d = S_RUN;
      end
      S_RUN: begin
        // Reads have no strobe (Adr is always driven), so only a write
        // attempt can flag an out-of-range access.
        if (MemWrite) begin
          if (out_of_range) begin
            err_d = 1'b1;
          end else begin
            we = 1'b1;
            if (misaligned) err_d = 1'b1;
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RESET_STATE;
      load_words_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_words_q <= load_words_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the array has no reset; it maps onto RAM and its contents survive
  // a reset, so an image loaded earlier stays readable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign load_words = load_words_q;
  assign err        = err_q;

  // A load always ends on a word boundary, so the assembler is idle in S_RUN.
  assert property (@(posedge clk) disable iff (!reset) run |-> byte_cnt == 2'd0);

endmodule

// File: tb/tb_mc_memory.sv
// Self-checking bench for mc_memory: loader sequences with a word
// scoreboard, a table of core accesses, and an overflow/no-boot instance.
module tb_mc_memory;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: ADDR_BITS=8, BOOT_LOAD=1
  logic [31:0] a_adr, a_wd, a_rd;
  logic        a_we, a_valid, a_last, a_ready, a_run, a_err;
  logic [7:0]  a_byte;
  logic [8:0]  a_lw;
  // Instance B: ADDR_BITS=2, BOOT_LOAD=1 (overflow)
  logic [31:0] b_adr, b_wd, b_rd;
  logic        b_we, b_valid, b_last, b_ready, b_run, b_err;
  logic [7:0]  b_byte;
  logic [2:0]  b_lw;
  // Instance C: ADDR_BITS=4, BOOT_LOAD=0
  logic [31:0] c_adr, c_wd, c_rd;
  logic        c_we, c_valid, c_last, c_ready, c_run, c_err;
  logic [7:0]  c_byte;
  logic [4:0]  c_lw;

  mc_memory #(.ADDR_BITS(8), .BOOT_LOAD(1'b1)) dut_a (
    .clk(clk), .reset(reset), .Adr(a_adr), .memoryWD(a_wd), .MemWrite(a_we),
    .memoryRD(a_rd), .ld_valid(a_valid), .ld_byte(a_byte), .ld_last(a_last),
    .ld_ready(a_ready), .cpu_run(a_run), .load_words(a_lw), .err(a_err));

  mc_memory #(.ADDR_BITS(2), .BOOT_LOAD(1'b1)) dut_b (
    .clk(clk), .reset(reset), .Adr(b_adr), .memoryWD(b_wd), .MemWrite(b_we),
    .memoryRD(b_rd), .ld_valid(b_valid), .ld_byte(b_byte), .ld_last(b_last),
    .ld_ready(b_ready), .cpu_run(b_run), .load_words(b_lw), .err(b_err));

  mc_memory #(.ADDR_BITS(4), .BOOT_LOAD(1'b0)) dut_c (
    .clk(clk), .reset(reset), .Adr(c_adr), .memoryWD(c_wd), .MemWrite(c_we),
    .memoryRD(c_rd), .ld_valid(c_valid), .ld_byte(c_byte), .ld_last(c_last),
    .ld_ready(c_ready), .cpu_run(c_run), .load_words(c_lw), .err(c_err));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- loader model and word scoreboard ----------------
  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_word_t;

  exp_word_t   sb_a[$];
  exp_word_t   sb_b[$];
  int          m_cnt  [2];
  int          m_lw   [2];
  logic [31:0] m_word [2];
  int          depth  [2] = '{256, 4};

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_cnt[w]  = 0;
      m_lw[w]   = 0;
      m_word[w] = '0;
    end
  endtask

  task automatic model_byte(input int w, input logic [7:0] b, input bit last);
    exp_word_t e;
    m_word[w] = m_word[w] | ({24'b0, b} << (24 - 8 * m_cnt[w]));
    if (m_cnt[w] == 3 || last) begin
      if (m_lw[w] < depth[w]) begin
        e.idx  = m_lw[w];
        e.data = m_word[w];
        if (w == 0) sb_a.push_back(e); else sb_b.push_back(e);
        m_lw[w]++;
      end
      m_word[w] = '0;
      m_cnt[w]  = 0;
    end else begin
      m_cnt[w]++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Drives one byte for a cycle; checks the loader-phase outputs before the edge.
  task automatic send_byte(input int w, input logic [7:0] b, input bit last);
    if (w == 0) begin
      a_valid = 1'b1; a_byte = b; a_last = last;
    end else begin
      b_valid = 1'b1; b_byte = b; b_last = last;
    end
    @(negedge clk);
    if (w == 0) begin
      check("a_ld_ready_loading", a_ready, 1);
      check("a_cpu_run_loading", a_run, 0);
      check("a_rd_zero_loading", a_rd, 0);
    end else begin
      check("b_ld_ready_loading", b_ready, 1);
    end
    model_byte(w, b, last);
    @(posedge clk);
    #1;
    a_valid = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic read_word(input int w, input int idx, input logic [31:0] exp);
    if (w == 0) begin
      a_adr = 32'(idx) << 2; a_we = 1'b0;
    end else begin
      b_adr = 32'(idx) << 2; b_we = 1'b0;
    end
    @(negedge clk);
    if (w == 0) check($sformatf("a_mem[%0d]", idx), a_rd, exp);
    else        check($sformatf("b_mem[%0d]", idx), b_rd, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic check_words(input int w);
    exp_word_t e;
    if (w == 0) begin
      while (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        read_word(0, e.idx, e.data);
      end
    end else begin
      while (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        read_word(1, e.idx, e.data);
      end
    end
  endtask

  // ---------------- core-access vector table (instance A) ----------------
  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_err;
    logic        exp_err;
  } row_t;

  row_t        rows [12];
  logic [31:0] rd_q[$];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      a_adr = rows[i].adr;
      a_wd  = rows[i].wd;
      a_we  = rows[i].we;
      if (rows[i].chk_rd) rd_q.push_back(rows[i].exp_rd);
      @(negedge clk);
      if (rows[i].chk_rd) check($sformatf("row%0d_rd", i), a_rd, rd_q.pop_front());
      @(posedge clk);
      #1;
      a_we = 1'b0;
      if (rows[i].chk_err) check($sformatf("row%0d_err", i), a_err, rows[i].exp_err);
    end
  endtask

  initial begin
    //            adr           wd            we  chk  rd            chke err
    rows[0]  = '{32'h10,  32'h12345678, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    rows[1]  = '{32'h10,  32'hDEADBEEF, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0};
    rows[2]  = '{32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
    rows[3]  = '{32'h13,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
    rows[4]  = '{32'h20,  32'h0F0F0F0F, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    rows[5]  = '{32'h20,  32'h0,        1'b0, 1'b1, 32'h0F0F0F0F, 1'b1, 1'b0};
    rows[6]  = '{32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
    rows[7]  = '{32'h400, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0};
    rows[8]  = '{32'h404, 32'hAAAAAAAA, 1'b1, 1'b1, 32'h0,        1'b1, 1'b1};
    rows[9]  = '{32'h4,   32'h0,        1'b0, 1'b1, 32'h09000000, 1'b1, 1'b1};
    rows[10] = '{32'h6,   32'hCAFEF00D, 1'b1, 1'b1, 32'h09000000, 1'b1, 1'b1};
    rows[11] = '{32'h4,   32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1};

    reset = 1'b0;
    a_adr = '0; a_wd = '0; a_we = 1'b0; a_valid = 1'b0; a_byte = '0; a_last = 1'b0;
    b_adr = '0; b_wd = '0; b_we = 1'b0; b_valid = 1'b0; b_byte = '0; b_last = 1'b0;
    c_adr = '0; c_wd = '0; c_we = 1'b0; c_valid = 1'b1; c_byte = 8'hFF; c_last = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_a_ld_ready", a_ready, 1);
    check("rst_a_cpu_run", a_run, 0);
    check("rst_a_load_words", a_lw, 0);
    check("rst_a_err", a_err, 0);
    check("rst_a_rd", a_rd, 0);
    check("rst_c_cpu_run", c_run, 1);
    check("rst_c_ld_ready", c_ready, 0);
    check("rst_c_load_words", c_lw, 0);
    @(posedge clk);
    #1;

    // Overflow on the 4-word instance: 20 bytes, fifth commit dropped
    for (int i = 0; i < 20; i++) begin
      send_byte(1, 8'(i + 1), i == 19);
      if (i == 15) begin
        check("ovf_lw_full", b_lw, 4);
        check("ovf_err_before", b_err, 0);
      end
    end
    check("ovf_err", b_err, 1);
    check("ovf_load_words", b_lw, 4);
    check("ovf_cpu_run", b_run, 1);
    check("ovf_ld_ready", b_ready, 0);
    check_words(1);
    read_word(1, 0, 32'h01020304);

    // Single-word image
    send_byte(0, 8'h20, 0);
    send_byte(0, 8'h08, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h05, 1);
    check("t1_cpu_run", a_run, 1);
    check("t1_ld_ready", a_ready, 0);
    check("t1_load_words", a_lw, 1);
    check_words(0);
    read_word(0, 0, 32'h20080005);
    run_rows(0, 4);

    // Two-word image; core writes during load must be ignored
    do_reset();
    a_we = 1'b1; a_adr = 32'h20; a_wd = 32'hBAD0BAD0;
    send_byte(0, 8'h11, 0); send_byte(0, 8'h22, 0);
    send_byte(0, 8'h33, 0); send_byte(0, 8'h44, 0);
    send_byte(0, 8'hAA, 0); send_byte(0, 8'hBB, 0);
    send_byte(0, 8'hCC, 0); send_byte(0, 8'hDD, 1);
    a_we = 1'b0;
    check("t2_load_words", a_lw, 2);
    check_words(0);
    read_word(0, 1, 32'hAABBCCDD);
    run_rows(5, 6);

    // Partial trailing word is zero-filled
    do_reset();
    send_byte(0, 8'h11, 0); send_byte(0, 8'h22, 0);
    send_byte(0, 8'h33, 0); send_byte(0, 8'h44, 0);
    send_byte(0, 8'h55, 1);
    check("t3_load_words", a_lw, 2);
    check_words(0);
    read_word(0, 1, 32'h55000000);

    // Reset mid-load discards the partial word
    do_reset();
    send_byte(0, 8'hAA, 0);
    send_byte(0, 8'hBB, 0);
    do_reset();
    check("mid_load_words", a_lw, 0);
    check("mid_cpu_run", a_run, 0);
    send_byte(0, 8'h01, 0); send_byte(0, 8'h02, 0);
    send_byte(0, 8'h03, 0); send_byte(0, 8'h04, 0);
    check("mid_load_words_1", a_lw, 1);
    check("mid_cpu_run_held", a_run, 0);
    send_byte(0, 8'h09, 1);
    check("mid_cpu_run_after", a_run, 1);
    check_words(0);
    read_word(0, 0, 32'h01020304);

    // Out-of-range accesses
    run_rows(7, 9);

    // Misaligned write
    do_reset();
    check("mis_err_cleared", a_err, 0);
    send_byte(0, 8'h77, 1);
    check_words(0);
    run_rows(10, 11);

    // No-boot instance: loader ignored, core port live from reset
    c_adr = 32'h8; c_wd = 32'h13572468; c_we = 1'b1;
    @(posedge clk);
    #1;
    c_we = 1'b0;
    @(negedge clk);
    check("c_rd_after_write", c_rd, 32'h13572468);
    check("c_load_words", c_lw, 0);
    check("c_err", c_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
